// File: rtl/slow_clk_pkg.sv
// Shared types and BCD helpers for the slow-clock edge counter.
package slow_clk_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

  // Digits above 9 still get weighted; callers pair this with bcd_valid.
  function automatic int unsigned bcd_to_bin(input logic [31:0] bcd, input int unsigned digits);
    int unsigned acc;
    int unsigned weight;
    acc    = 0;
    weight = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      acc    = acc + int'(bcd[i*BCD_W +: BCD_W]) * weight;
      weight = weight * 10;
    end
    return acc;
  endfunction

  function automatic logic [31:0] bin_to_bcd(input int unsigned bin);
    logic [31:0] res;
    int unsigned rem;
    res = '0;
    rem = bin;
    for (int unsigned i = 0; i < 8; i++) begin
      res[i*BCD_W +: BCD_W] = 4'(rem % 10);
      rem = rem / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/slow_clk_edge_counter_sync_edge.sv
// Synchronises the slow clock as data and emits a registered one-cycle pulse per rising edge.
module slow_clk_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic slow_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], slow_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign rise_pulse = r_rise;

endmodule

// File: rtl/slow_clk_edge_counter.sv
// Run/stop controlled, loadable BCD up/down counter stepped by rising edges of a slow clock.
module slow_clk_edge_counter
  import slow_clk_pkg::*;
#(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned MAX_COUNT   = 59,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slow_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load_en,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  up_down,
  output logic                  rise_pulse,
  output logic [4*DIGITS-1:0]   bcd_count,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  running
);

  localparam int unsigned  W       = BCD_W * DIGITS;
  localparam logic [W-1:0] MAX_BCD = W'(bin_to_bcd(MAX_COUNT));

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("slow_clk_edge_counter: DIGITS must be 1..8");
  end
  if (MAX_COUNT >= 10**DIGITS) begin : g_bad_max
    $error("slow_clk_edge_counter: MAX_COUNT must be < 10**DIGITS");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("slow_clk_edge_counter: SYNC_STAGES must be 2..4");
  end

  state_t       r_state;
  state_t       w_state_next;
  logic         r_running;
  logic [W-1:0] r_count;
  logic         r_wrap;
  logic         r_load_err;
  logic         w_rise;
  logic         w_step;
  logic         w_load_ok;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;

  slow_clk_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .slow_in   (slow_in),
    .rise_pulse(w_rise)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOP: if (start && !stop) w_state_next = ST_RUN;
      ST_RUN:  if (stop)           w_state_next = ST_STOP;
      default:                     w_state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
    end
  end

  always_comb begin
    w_load_ok = (bcd_to_bin(32'(load_value), DIGITS) <= MAX_COUNT);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_value[i*BCD_W +: BCD_W])) w_load_ok = 1'b0;
    end
  end

  // Ripple carry/borrow across digits; the MAX/zero wrap cases are handled in the register.
  always_comb begin
    logic carry;
    logic borrow;
    w_inc  = r_count;
    w_dec  = r_count;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r_count[i*BCD_W +: BCD_W] == 4'd9) begin
          w_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          w_inc[i*BCD_W +: BCD_W] = r_count[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (r_count[i*BCD_W +: BCD_W] == 4'd0) begin
          w_dec[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          w_dec[i*BCD_W +: BCD_W] = r_count[i*BCD_W +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign w_step = (r_state == ST_RUN) && w_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else if (load_en) begin
        if (w_load_ok) r_count    <= load_value;
        else           r_load_err <= 1'b1;
      end else if (w_step) begin
        if (up_down) begin
          if (r_count == MAX_BCD) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= w_inc;
          end
        end else begin
          if (r_count == '0) begin
            r_count <= MAX_BCD;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= w_dec;
          end
        end
      end
    end
  end

  assign rise_pulse = w_rise;
  assign bcd_count  = r_count;
  assign wrap       = r_wrap;
  assign load_err   = r_load_err;
  assign running    = r_running;

endmodule
